// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key-event path.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GOT_E0,
    ST_GOT_F0,
    ST_GOT_E0F0,
    ST_PAUSE
  } ps2_state_t;

  localparam logic [7:0] PS2_E0 = 8'hE0;
  localparam logic [7:0] PS2_E1 = 8'hE1;
  localparam logic [7:0] PS2_F0 = 8'hF0;

  // Keyboard protocol/status bytes that never form part of a key event.
  localparam int unsigned PS2_NUM_STATUS = 7;
  localparam logic [7:0] PS2_STATUS [PS2_NUM_STATUS] =
    '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ps2_evt_t;

  function automatic logic is_status_byte(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < PS2_NUM_STATUS; i++) begin
      if (b == PS2_STATUS[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous event FIFO; a push into a full FIFO succeeds only alongside a pop.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     ck,
  input  logic                     reset,
  input  logic                     push,
  input  ps2_evt_t                 wr_data,
  input  logic                     pop,
  output ps2_evt_t                 rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  ps2_evt_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// Parses the PS/2 scan-code byte stream into whole key events and queues them.
module ps2_key_event_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 2500000
) (
  input  logic                     ck,
  input  logic                     reset,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_in,
  input  logic                     evt_ready,
  output logic                     evt_valid,
  output logic [7:0]               evt_code,
  output logic                     evt_ext,
  output logic                     evt_break,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  input  logic                     clr_overflow
);

  localparam int unsigned TW = ($clog2(TIMEOUT_CYC) < 1) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  ps2_state_t    state, state_nxt;
  logic [2:0]    pause_cnt, pause_nxt;
  logic [TW-1:0] to_cnt, to_nxt;
  logic          byte_q;
  logic          take;
  logic          push;
  ps2_evt_t      push_evt;
  ps2_evt_t      head_evt;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          drop;

  assign take = byte_valid && !byte_q;
  assign pop  = evt_ready && !fifo_empty;
  assign drop = push && fifo_full && !pop;

  // Parser state, pause/timeout counters and the byte_valid edge register.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      pause_cnt <= '0;
      to_cnt    <= '0;
      byte_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      pause_cnt <= pause_nxt;
      to_cnt    <= to_nxt;
      byte_q    <= byte_valid;
    end
  end

  // Next-state decode; an accepted byte always takes precedence over timeout.
  always_comb begin
    state_nxt = state;
    pause_nxt = pause_cnt;
    to_nxt    = '0;
    push      = 1'b0;
    push_evt  = '0;
    if (state != ST_IDLE) to_nxt = to_cnt + 1'b1;
    if (take) begin
      to_nxt = '0;
      if (state != ST_PAUSE && is_status_byte(byte_in)) begin
        state_nxt = ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (byte_in == PS2_E0) begin
              state_nxt = ST_GOT_E0;
            end else if (byte_in == PS2_F0) begin
              state_nxt = ST_GOT_F0;
            end else if (byte_in == PS2_E1) begin
              state_nxt = ST_PAUSE;
              pause_nxt = '0;
            end else begin
              push     = 1'b1;
              push_evt = '{code: byte_in, ext: 1'b0, brk: 1'b0};
            end
          end
          ST_GOT_E0: begin
            if (byte_in == PS2_F0) begin
              state_nxt = ST_GOT_E0F0;
            end else if (byte_in != PS2_E0) begin
              push      = 1'b1;
              push_evt  = '{code: byte_in, ext: 1'b1, brk: 1'b0};
              state_nxt = ST_IDLE;
            end
          end
          ST_GOT_F0: begin
            if (byte_in != PS2_F0) begin
              push      = 1'b1;
              push_evt  = '{code: byte_in, ext: 1'b0, brk: 1'b1};
              state_nxt = ST_IDLE;
            end
          end
          ST_GOT_E0F0: begin
            push      = 1'b1;
            push_evt  = '{code: byte_in, ext: 1'b1, brk: 1'b1};
            state_nxt = ST_IDLE;
          end
          ST_PAUSE: begin
            if (pause_cnt == 3'd6) begin
              push      = 1'b1;
              push_evt  = '{code: PS2_E1, ext: 1'b0, brk: 1'b0};
              state_nxt = ST_IDLE;
              pause_nxt = '0;
            end else begin
              pause_nxt = pause_cnt + 1'b1;
            end
          end
          default: state_nxt = ST_IDLE;
        endcase
      end
    end else if (state != ST_IDLE && to_cnt == TO_LAST) begin
      state_nxt = ST_IDLE;
      pause_nxt = '0;
      to_nxt    = '0;
    end
  end

  // Sticky drop flag; a new drop outranks a simultaneous clear.
  always_ff @(posedge ck or posedge reset) begin
    if (reset)             overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

  ps2_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .ck      (ck),
    .reset   (reset),
    .push    (push),
    .wr_data (push_evt),
    .pop     (pop),
    .rd_data (head_evt),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign evt_valid = !fifo_empty;
  assign evt_code  = head_evt.code;
  assign evt_ext   = head_evt.ext;
  assign evt_break = head_evt.brk;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Bench for ps2_key_event_ctrl: directed and random byte streams against a reference model.
module tb_ps2_key_event_ctrl;

  localparam int DEPTH = 4;
  localparam int TOUT  = 100;

  logic       ck = 1'b0;
  logic       reset = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_in = '0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       clr_overflow = 1'b0;

  int errors = 0;
  int checks = 0;

  // Reference model state: which prefixes have been seen since the last
  // event, bytes still to swallow after E1, idle edges while a prefix waits.
  bit        m_ext, m_brk;
  int        m_pause_left;
  int        m_wait;
  bit        m_bv_prev;
  bit        m_ovf;
  logic [9:0] mq[$];

  ps2_key_event_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYC(TOUT)) dut (
    .ck           (ck),
    .reset        (reset),
    .byte_valid   (byte_valid),
    .byte_in      (byte_in),
    .evt_ready    (evt_ready),
    .evt_valid    (evt_valid),
    .evt_code     (evt_code),
    .evt_ext      (evt_ext),
    .evt_break    (evt_break),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_status(input logic [7:0] b);
    return b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA ||
           b == 8'hFC || b == 8'hFE || b == 8'hFF;
  endfunction

  function automatic bit prefix_pending();
    return m_ext || m_brk || (m_pause_left > 0);
  endfunction

  function automatic void model_clear_prefix();
    m_ext = 0; m_brk = 0; m_pause_left = 0; m_wait = 0;
  endfunction

  // Interpret one accepted byte; returns whether it completes an event.
  function automatic bit model_byte(input logic [7:0] b, output logic [9:0] ev);
    bit has = 0;
    ev = '0;
    if (m_pause_left > 0) begin
      m_pause_left--;
      if (m_pause_left == 0) begin has = 1; ev = {8'hE1, 2'b00}; end
    end else if (is_status(b)) begin
      model_clear_prefix();
    end else if (m_brk) begin
      if (!(b == 8'hF0 && !m_ext)) begin
        has = 1; ev = {b, m_ext, 1'b1}; model_clear_prefix();
      end
    end else if (m_ext) begin
      if (b == 8'hF0) m_brk = 1;
      else if (b != 8'hE0) begin has = 1; ev = {b, 2'b10}; model_clear_prefix(); end
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE1) m_pause_left = 7;
    else begin has = 1; ev = {b, 2'b00}; end
    return has;
  endfunction

  // One clock: drive inputs, advance the model, then check the DUT after the edge.
  task automatic step(input bit bv, input logic [7:0] b, input bit rdy, input bit clr);
    bit take, pop, has, drop;
    logic [9:0] ev;
    byte_valid = bv; byte_in = b; evt_ready = rdy; clr_overflow = clr;
    take = bv && !m_bv_prev;
    m_bv_prev = bv;
    has = 0; drop = 0;
    if (take) begin
      m_wait = 0;
      has = model_byte(b, ev);
    end else if (prefix_pending()) begin
      m_wait++;
      if (m_wait == TOUT) model_clear_prefix();
    end
    pop = rdy && (mq.size() > 0);
    if (pop) void'(mq.pop_front());
    if (has) begin
      if (mq.size() < DEPTH) mq.push_back(ev);
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
    @(posedge ck); #1;
    chk("evt_valid", 32'(evt_valid), 32'(mq.size() > 0));
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (mq.size() > 0) begin
      chk("evt_code", 32'(evt_code), 32'(mq[0][9:2]));
      chk("evt_ext", 32'(evt_ext), 32'(mq[0][1]));
      chk("evt_break", 32'(evt_break), 32'(mq[0][0]));
    end
  endtask

  task automatic send(input logic [7:0] b, input int hold, input bit rdy);
    for (int i = 0; i < hold; i++) step(1, b, rdy, 0);
    step(0, b, rdy, 0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 8'h00, rdy, 0);
  endtask

  task automatic do_reset();
    byte_valid = 0; evt_ready = 0; clr_overflow = 0;
    reset = 1;
    #2;
    mq.delete(); model_clear_prefix(); m_bv_prev = 0; m_ovf = 0;
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_code", 32'(evt_code), 0);
    chk("rst_ext", 32'(evt_ext), 0);
    chk("rst_break", 32'(evt_break), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    @(posedge ck); #1;
    reset = 0;
  endtask

  initial begin
    logic [7:0] rb;
    int sel;
    model_clear_prefix(); m_bv_prev = 0; m_ovf = 0;
    #1;
    do_reset();

    // Level held high yields a single event, visible right after the sampling edge.
    send(8'h1C, 10, 0);
    idle(3, 1);

    // Extended break, plain break, prefix bytes alone produce nothing.
    send(8'hE0, 1, 0); send(8'hF0, 1, 0); send(8'h74, 1, 0);
    send(8'hF0, 2, 0); send(8'h1C, 1, 0);
    idle(4, 1);

    // Pause sequence then a normal make.
    send(8'hE1, 1, 0); send(8'h14, 1, 0); send(8'h77, 1, 0); send(8'hE1, 1, 0);
    send(8'hF0, 1, 0); send(8'h14, 1, 0); send(8'hF0, 1, 0); send(8'h77, 1, 0);
    send(8'h1C, 1, 0);
    idle(4, 1);

    // Timeout boundary: one edge short keeps the E0, the full count drops it.
    send(8'hE0, 1, 0); idle(TOUT - 2, 0); send(8'h1C, 1, 0);
    send(8'hE0, 1, 0); idle(TOUT + 5, 0); send(8'h1C, 1, 0);
    send(8'hE1, 1, 0); send(8'h11, 1, 0); idle(TOUT + 2, 0); send(8'h1C, 1, 0);
    idle(4, 1);

    // Overflow: DEPTH+1 makes with no reads, then clear, then push-with-pop on full.
    for (int i = 0; i <= DEPTH; i++) send(8'h15 + 8'(i), 1, 0);
    step(0, 8'h00, 0, 1);
    step(1, 8'h2A, 1, 0);
    step(0, 8'h00, 0, 0);
    idle(6, 1);

    // Reset mid-sequence with events stored.
    send(8'h1C, 1, 0); send(8'h32, 1, 0); send(8'hF0, 1, 0);
    do_reset();
    send(8'h1C, 1, 0);
    send(8'hFA, 1, 0); send(8'hAA, 1, 0);
    send(8'hE0, 1, 0); send(8'hFA, 1, 0); send(8'h1C, 1, 0);
    idle(4, 1);

    // Random byte stream with random consumer backpressure.
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 11);
      if (sel <= 5)      rb = 8'($urandom_range(1, 255));
      else if (sel <= 7) rb = 8'hE0;
      else if (sel <= 9) rb = 8'hF0;
      else if (sel == 10) rb = ($urandom_range(0, 1) == 1) ? 8'hFA : 8'hAA;
      else               rb = 8'hE1;
      for (int h = 0; h < int'($urandom_range(1, 3)); h++)
        step(1, rb, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 15) == 0));
      for (int g = 0; g < int'($urandom_range(1, 3)); g++)
        step(0, rb, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 15) == 0));
    end
    idle(DEPTH + 4, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
